piso_shifter: RTL and testbench

PISO_SHIFTER -- requirements
Module: piso_shifter

---
 rtl/piso_shifter_if.sv | 23 ++
 rtl/piso_shifter.sv | 79 +++++++
 tb/tb_piso_shifter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/piso_shifter_if.sv
// rtl/piso_shifter_if.sv - parallel load handshake and serial output bundle for piso_shifter
interface piso_shifter_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] data_in;
    logic             in_valid;
    logic             in_ready;
    logic             shift_en;
    logic             sout;
    logic             sout_valid;
    logic             sout_last;
    logic             frame_done;

    modport master (
        output data_in, in_valid, shift_en,
        input  in_ready, sout, sout_valid, sout_last, frame_done
    );

    modport slave (
        input  data_in, in_valid, shift_en,
        output in_ready, sout, sout_valid, sout_last, frame_done
    );
endinterface

// File: rtl/piso_shifter.sv
// rtl/piso_shifter.sv - parallel-in serial-out shifter with stall strobe and back-to-back preload
module piso_shifter #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    piso_shifter_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   shreg, shreg_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               done_q, done_nxt;
    logic               is_last;
    logic               out_bit;

    assign is_last = (state == SHIFT) && (cnt == CNT_W'(WIDTH - 1));
    assign out_bit = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            shreg  <= '0;
            cnt    <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            shreg  <= shreg_nxt;
            cnt    <= cnt_nxt;
            done_q <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    shreg_nxt = bus.data_in;
                    cnt_nxt   = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.shift_en) begin
                    if (is_last) begin
                        done_nxt = 1'b1;
                        // Preload the next word on the final strobe so frames abut with no gap
                        if (bus.in_valid) begin
                            shreg_nxt = bus.data_in;
                            cnt_nxt   = '0;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        shreg_nxt = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0}
                                              : {1'b0, shreg[WIDTH-1:1]};
                        cnt_nxt   = cnt + CNT_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Combinational outputs are forced low while reset is held
    assign bus.in_ready   = rst & ((state == IDLE) | (is_last & bus.shift_en));
    assign bus.sout_valid = rst & (state == SHIFT);
    assign bus.sout       = rst & (state == SHIFT) & out_bit;
    assign bus.sout_last  = rst & is_last;
    assign bus.frame_done = done_q;
endmodule

// File: tb/tb_piso_shifter.sv
// tb/tb_piso_shifter.sv - directed vector bench for piso_shifter (LSB/MSB 8-bit and LSB 16-bit)
module tb_piso_shifter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    piso_shifter_if #(.WIDTH(8))  if_lsb ();
    piso_shifter_if #(.WIDTH(8))  if_msb ();
    piso_shifter_if #(.WIDTH(16)) if_w16 ();

    piso_shifter #(.WIDTH(8),  .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .rst(rst), .bus(if_lsb.slave));
    piso_shifter #(.WIDTH(8),  .MSB_FIRST(1'b1)) u_msb (.clk(clk), .rst(rst), .bus(if_msb.slave));
    piso_shifter #(.WIDTH(16), .MSB_FIRST(1'b0)) u_w16 (.clk(clk), .rst(rst), .bus(if_w16.slave));

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       s;
        logic       e_lsb;
        logic       e_msb;
        logic       e_val;
        logic       e_last;
        logic       e_done;
        logic       e_rdy;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive8(input logic v, input logic [7:0] d, input logic s);
        if_lsb.in_valid = v; if_lsb.data_in = d; if_lsb.shift_en = s;
        if_msb.in_valid = v; if_msb.data_in = d; if_msb.shift_en = s;
    endtask

    task automatic drive16(input logic v, input logic [15:0] d, input logic s);
        if_w16.in_valid = v; if_w16.data_in = d; if_w16.shift_en = s;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] w3c;
        w3c = 8'h3C;

        vecs[0]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 8'h1E, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[18] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[19] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        // Reset with inputs active: outputs must stay quiet
        drive8(1'b1, 8'hFF, 1'b1);
        drive16(1'b0, 16'h0, 1'b0);
        #1;
        chk("rst_ready",  if_lsb.in_ready, 1'b0);
        chk("rst_valid",  if_lsb.sout_valid, 1'b0);
        chk("rst_sout",   if_msb.sout, 1'b0);
        next_cycle();
        next_cycle();
        chk("rst_done",   if_lsb.frame_done, 1'b0);
        chk("rst_valid2", if_msb.sout_valid, 1'b0);
        rst = 1'b1;

        // Table: A5 then 1E, continuous shift_en
        for (int i = 0; i < 20; i++) begin
            drive8(vecs[i].v, vecs[i].d, vecs[i].s);
            #1;
            chk($sformatf("tbl%0d_sout_lsb", i), if_lsb.sout, vecs[i].e_lsb);
            chk($sformatf("tbl%0d_sout_msb", i), if_msb.sout, vecs[i].e_msb);
            chk($sformatf("tbl%0d_valid", i), if_lsb.sout_valid, vecs[i].e_val);
            chk($sformatf("tbl%0d_valid_msb", i), if_msb.sout_valid, vecs[i].e_val);
            chk($sformatf("tbl%0d_last", i), if_lsb.sout_last, vecs[i].e_last);
            chk($sformatf("tbl%0d_last_msb", i), if_msb.sout_last, vecs[i].e_last);
            chk($sformatf("tbl%0d_done", i), if_lsb.frame_done, vecs[i].e_done);
            chk($sformatf("tbl%0d_ready", i), if_lsb.in_ready, vecs[i].e_rdy);
            @(posedge clk);
            #1;
        end

        // Stalled shifting: strobe every third cycle, word 3C
        drive8(1'b1, 8'h3C, 1'b0);
        #1;
        chk("stall_accept_ready", if_lsb.in_ready, 1'b1);
        next_cycle();
        for (int k = 0; k < 24; k++) begin
            drive8(1'b0, 8'hC3, (k % 3) == 2);
            #1;
            chk($sformatf("stall%0d_lsb", k), if_lsb.sout, w3c[k/3]);
            chk($sformatf("stall%0d_msb", k), if_msb.sout, w3c[7 - k/3]);
            chk($sformatf("stall%0d_valid", k), if_lsb.sout_valid, 1'b1);
            chk($sformatf("stall%0d_last", k), if_lsb.sout_last, (k / 3) == 7);
            chk($sformatf("stall%0d_done", k), if_lsb.frame_done, 1'b0);
            next_cycle();
        end
        drive8(1'b0, 8'h00, 1'b0);
        #1;
        chk("stall_done", if_lsb.frame_done, 1'b1);
        chk("stall_idle", if_msb.sout_valid, 1'b0);
        next_cycle();

        // Back-to-back FF then 00; data_in changes mid-frame must not leak in
        drive8(1'b1, 8'hFF, 1'b1);
        next_cycle();
        for (int k = 1; k <= 17; k++) begin
            drive8(k <= 8, 8'h00, 1'b1);
            #1;
            if (k <= 16) begin
                chk($sformatf("b2b%0d_valid", k), if_lsb.sout_valid, 1'b1);
                chk($sformatf("b2b%0d_sout", k), if_lsb.sout, k <= 8);
                chk($sformatf("b2b%0d_ready", k), if_lsb.in_ready, (k == 8) || (k == 16));
            end else begin
                chk("b2b_end_valid", if_lsb.sout_valid, 1'b0);
            end
            chk($sformatf("b2b%0d_done", k), if_lsb.frame_done, (k == 9) || (k == 17));
            next_cycle();
        end

        // Mid-frame reset after 3 bits of 81
        drive8(1'b1, 8'h81, 1'b1);
        next_cycle();
        for (int k = 1; k <= 3; k++) begin
            drive8(1'b0, 8'h00, 1'b1);
            #1;
            chk($sformatf("abort_bit%0d", k), if_lsb.sout, k == 1);
            next_cycle();
        end
        rst = 1'b0;
        drive8(1'b1, 8'h55, 1'b1);
        #1;
        chk("abort_rst_ready", if_lsb.in_ready, 1'b0);
        chk("abort_rst_valid_comb", if_lsb.sout_valid, 1'b0);
        next_cycle();
        chk("abort_rst_valid", if_lsb.sout_valid, 1'b0);
        chk("abort_rst_done", if_lsb.frame_done, 1'b0);
        next_cycle();
        rst = 1'b1;
        drive8(1'b0, 8'h00, 1'b1);
        #1;
        chk("abort_post_ready", if_lsb.in_ready, 1'b1);
        chk("abort_post_valid", if_lsb.sout_valid, 1'b0);
        chk("abort_post_done", if_lsb.frame_done, 1'b0);
        drive8(1'b1, 8'h01, 1'b1);
        next_cycle();
        for (int k = 1; k <= 9; k++) begin
            drive8(1'b0, 8'h00, 1'b1);
            #1;
            if (k <= 8)
                chk($sformatf("reload%0d_sout", k), if_lsb.sout, k == 1);
            chk($sformatf("reload%0d_done", k), if_lsb.frame_done, k == 9);
            next_cycle();
        end

        // 16-bit LSB-first 8001
        drive16(1'b1, 16'h8001, 1'b1);
        next_cycle();
        for (int k = 1; k <= 17; k++) begin
            drive16(1'b0, 16'h0, 1'b1);
            #1;
            if (k <= 16) begin
                chk($sformatf("w16_%0d_sout", k), if_w16.sout, (k == 1) || (k == 16));
                chk($sformatf("w16_%0d_last", k), if_w16.sout_last, k == 16);
            end
            chk($sformatf("w16_%0d_done", k), if_w16.frame_done, k == 17);
            next_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
